// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, req/ack fetch from instruction memory,
// instruction register with opcode/funct fields, downstream stall and branch redirect.
module fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pc_out
);

  typedef enum logic [1:0] {FETCH, FLUSH, HOLD} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_pend_pc, w_pend_pc_nxt;
  logic [31:0]       r_instr, w_instr_nxt;
  logic [ADDR_W-1:0] r_pc_out, w_pc_out_nxt;
  logic              r_valid, w_valid_nxt;
  logic [ADDR_W-1:0] w_tgt;

  // Branch targets are word aligned; low address bits are forced to zero.
  assign w_tgt = {redirect_target[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_pend_pc <= '0;
      r_instr   <= '0;
      r_pc_out  <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_pc_out  <= w_pc_out_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pend_pc_nxt = r_pend_pc;
    w_instr_nxt   = r_instr;
    w_pc_out_nxt  = r_pc_out;
    w_valid_nxt   = r_valid;
    unique case (r_state)
      FETCH: begin
        if (imem_ack && !redirect) begin
          w_instr_nxt  = imem_rdata;
          w_pc_out_nxt = r_pc;
          w_pc_nxt     = r_pc + ADDR_W'(PC_STEP);
          w_valid_nxt  = 1'b1;
          w_state_nxt  = HOLD;
        end else if (imem_ack && redirect) begin
          w_pc_nxt = w_tgt;
        end else if (redirect) begin
          w_pend_pc_nxt = w_tgt;
          w_state_nxt   = FLUSH;
        end
      end
      FLUSH: begin
        // Memory still owes us a word for the old address; wait it out.
        if (imem_ack) begin
          w_pc_nxt    = redirect ? w_tgt : r_pend_pc;
          w_state_nxt = FETCH;
        end else if (redirect) begin
          w_pend_pc_nxt = w_tgt;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_valid_nxt = 1'b0;
          w_pc_nxt    = w_tgt;
          w_state_nxt = FETCH;
        end else if (!stall) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  assign imem_req    = !reset && (r_state != HOLD);
  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign pc_out      = r_pc_out;
  assign opcode      = r_instr[31:26];
  assign funct       = r_instr[5:0];

endmodule
